des_stream_ctrl: RTL and testbench

DES_STREAM_CTRL -- requirements
Module: des_stream_ctrl

---
 rtl/des_stream_ctrl_if.sv | 26 ++
 rtl/des_stream_ctrl.sv | 132 +++++++++++++
 tb/tb_des_stream_ctrl.sv | 427 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/des_stream_ctrl_if.sv
// Byte-stream and DES-core bundle for des_stream_ctrl.
// The slave modport is the controller side; the master modport is the feeder/consumer/core side.
interface des_stream_ctrl_if;
  logic        key_load;
  logic [63:0] key_in;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic [63:0] plain_text;
  logic [63:0] cipher_key;
  logic [63:0] cipher_text;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_ready;
  logic        busy;

  modport master (
    output key_load, key_in, in_valid, in_data, cipher_text, out_ready,
    input  in_ready, plain_text, cipher_key, out_valid, out_data, busy
  );

  modport slave (
    input  key_load, key_in, in_valid, in_data, cipher_text, out_ready,
    output in_ready, plain_text, cipher_key, out_valid, out_data, busy
  );
endinterface

// File: rtl/des_stream_ctrl.sv
// Byte-serial wrapper around a combinational DES core: gathers 8 plaintext bytes,
// waits SETTLE_CYCLES for the core, then streams the 8 ciphertext bytes MSB first.
module des_stream_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 32'd1
) (
  input logic           clk,
  input logic           rst,
  des_stream_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_FILL   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_DRAIN  = 2'd2
  } state_t;

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 32'd1);

  state_t      state_q, state_d;
  logic [2:0]  byte_cnt_q, byte_cnt_d;
  logic [3:0]  settle_cnt_q, settle_cnt_d;
  logic [63:0] plain_q, plain_d;
  logic [63:0] key_q, key_d;
  logic [63:0] shift_q, shift_d;
  logic        in_ready_q, in_ready_d;
  logic        out_valid_q, out_valid_d;
  logic        busy_q, busy_d;

  logic        in_fire_s;
  logic        out_fire_s;

  // Handshakes use the registered strobes, so ready/valid never depend on their partner.
  assign in_fire_s  = bus.in_valid && in_ready_q;
  assign out_fire_s = out_valid_q && bus.out_ready;

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_FILL;
      byte_cnt_q   <= 3'd0;
      settle_cnt_q <= 4'd0;
      plain_q      <= 64'd0;
      key_q        <= 64'd0;
      shift_q      <= 64'd0;
      in_ready_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      byte_cnt_q   <= byte_cnt_d;
      settle_cnt_q <= settle_cnt_d;
      plain_q      <= plain_d;
      key_q        <= key_d;
      shift_q      <= shift_d;
      in_ready_q   <= in_ready_d;
      out_valid_q  <= out_valid_d;
      busy_q       <= busy_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d      = state_q;
    byte_cnt_d   = byte_cnt_q;
    settle_cnt_d = settle_cnt_q;
    plain_d      = plain_q;
    key_d        = key_q;
    shift_d      = shift_q;
    case (state_q)
      ST_FILL: begin
        // A key load and the final byte may share an edge; that block uses the new key.
        if (bus.key_load) begin
          key_d = bus.key_in;
        end else begin
          key_d = key_q;
        end
        if (in_fire_s) begin
          plain_d[{~byte_cnt_q, 3'b000} +: 8] = bus.in_data;
          if (byte_cnt_q == 3'd7) begin
            state_d      = ST_SETTLE;
            byte_cnt_d   = 3'd0;
            settle_cnt_d = SETTLE_LOAD;
          end else begin
            byte_cnt_d = byte_cnt_q + 3'd1;
          end
        end else begin
          byte_cnt_d = byte_cnt_q;
        end
      end
      ST_SETTLE: begin
        if (settle_cnt_q == 4'd0) begin
          shift_d = bus.cipher_text;
          state_d = ST_DRAIN;
        end else begin
          settle_cnt_d = settle_cnt_q - 4'd1;
        end
      end
      ST_DRAIN: begin
        if (out_fire_s) begin
          shift_d = {shift_q[55:0], 8'h00};
          if (byte_cnt_q == 3'd7) begin
            state_d    = ST_FILL;
            byte_cnt_d = 3'd0;
          end else begin
            byte_cnt_d = byte_cnt_q + 3'd1;
          end
        end else begin
          shift_d = shift_q;
        end
      end
      default: begin
        state_d    = ST_FILL;
        byte_cnt_d = 3'd0;
      end
    endcase
  end

  // Output strobes are computed from the next state so they can be registered.
  always_comb begin
    in_ready_d  = (state_d == ST_FILL);
    out_valid_d = (state_d == ST_DRAIN);
    busy_d      = (state_d != ST_FILL) || (byte_cnt_d != 3'd0);
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = shift_q[63:56];
  assign bus.busy       = busy_q;
  assign bus.plain_text = plain_q;
  assign bus.cipher_key = key_q;

endmodule

// File: tb/tb_des_stream_ctrl.sv
// Scoreboard bench for des_stream_ctrl with a behavioural DES core on cipher_text.
module tb_des_stream_ctrl;
  localparam int SETTLE = 3;
  localparam logic [63:0] KAT_KEY = 64'h133457799BBCDFF1;

  localparam int IP_T [64] = '{58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4,
                               62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8,
                               57,49,41,33,25,17,9,1,  59,51,43,35,27,19,11,3,
                               61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
  localparam int PC1_T [56] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18,
                                10,2,59,51,43,35,27, 19,11,3,60,52,44,36,
                                63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
                                14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
  localparam int PC2_T [48] = '{14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8, 16,7,27,20,13,2,
                                41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32};
  localparam int P_T [32] = '{16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10,
                              2,8,24,14,32,27,3,9, 19,13,30,6,22,11,4,25};
  localparam int SH_T [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
  localparam logic [255:0] SBOX [8] = '{
    256'hE4D12FB83A6C59070F74E2D1A6CB953841E8D62BFC973A50FC8249175B3EA06D,
    256'hF18E6B34972DC05A3D47F28EC01A69B50E7BA4D158C6932FD8A13F42B67C05E9,
    256'hA09E63F51DC7B428D70934A6285ECBF1D6498F30B12C5AE71AD069874FE3B52C,
    256'h7DE3069A1285BC4FD8B56F03472C1AE9A690CB7DF13E52843F06A1D8945BC72E,
    256'h2C417AB6853FD0E9EB2C47D150FA3986421BAD78F9C5630EB8C71E2D6F09A453,
    256'hC1AF92680D34E75BAF427C9561DE0B389EF528C3704A1DB6432C95FABE17608D,
    256'h4B2EF08D3C975A61D0B7491AE35C2F8614BDC37EAF6805926BD814A7950FE23C,
    256'hD2846FB1A93E50C71FD8A374C56B0E927B419CE206ADF35821E74A8DFC90356B};

  logic clk = 1'b0;
  logic rst = 1'b0;
  des_stream_ctrl_if bus ();

  des_stream_ctrl #(.SETTLE_CYCLES(SETTLE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [7:0]  exp_q [$];
  logic [63:0] model_key = 64'd0;
  logic        stall_seen = 1'b0;
  logic [7:0]  stall_byte;
  logic [7:0]  exp_b;

  function automatic logic [63:0] des_enc(input logic [63:0] pt, input logic [63:0] key);
    logic [63:0] ipv, pre, res;
    logic [55:0] cd;
    logic [27:0] c, d;
    logic [47:0] k, e;
    logic [31:0] l, r, sout, f, t;
    logic [5:0]  six;
    logic [255:0] sb;
    int idx;
    for (int i = 0; i < 64; i++) ipv[63-i] = pt[64-IP_T[i]];
    for (int i = 0; i < 56; i++) cd[55-i] = key[64-PC1_T[i]];
    c = cd[55:28];
    d = cd[27:0];
    l = ipv[63:32];
    r = ipv[31:0];
    for (int rd = 0; rd < 16; rd++) begin
      for (int s = 0; s < SH_T[rd]; s++) begin
        c = {c[26:0], c[27]};
        d = {d[26:0], d[27]};
      end
      cd = {c, d};
      for (int i = 0; i < 48; i++) k[47-i] = cd[56-PC2_T[i]];
      for (int i = 0; i < 48; i++) e[47-i] = r[31 - (((i / 6) * 4 + (i % 6) + 31) % 32)];
      e = e ^ k;
      for (int s = 0; s < 8; s++) begin
        six = e[47-6*s -: 6];
        idx = int'({six[5], six[0]}) * 16 + int'(six[4:1]);
        sb = SBOX[s];
        sout[31-4*s -: 4] = sb[255-4*idx -: 4];
      end
      for (int i = 0; i < 32; i++) f[31-i] = sout[32-P_T[i]];
      t = l ^ f;
      l = r;
      r = t;
    end
    pre = {r, l};
    for (int i = 0; i < 64; i++) res[64-IP_T[i]] = pre[63-i];
    return res;
  endfunction

  assign bus.cipher_text = des_enc(bus.plain_text, bus.cipher_key);

  // Output monitor: pops the scoreboard on each transfer and checks stalled bytes hold.
  always @(negedge clk or posedge rst) begin
    if (rst) begin
      stall_seen = 1'b0;
    end else begin
      if (stall_seen) begin
        n_cmp++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== stall_byte) begin
          n_bad++;
          $display("FAIL stall_hold: got valid=%b data=%h, expected valid=1 data=%h", bus.out_valid, bus.out_data, stall_byte);
        end
      end
      if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL out_unexpected: got byte %h, expected no output", bus.out_data);
        end else begin
          exp_b = exp_q.pop_front();
          if (bus.out_data !== exp_b) begin
            n_bad++;
            $display("FAIL out_byte: got %h expected %h", bus.out_data, exp_b);
          end
        end
        stall_seen = 1'b0;
      end else if (bus.out_valid === 1'b1) begin
        stall_seen = 1'b1;
        stall_byte = bus.out_data;
      end else begin
        stall_seen = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] d, input int gap, input bit hold, input bit kl, input logic [63:0] k);
    int w;
    for (int g = 0; g < gap; g++) begin
      bus.in_valid = 1'b0;
      tick();
    end
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.key_load = kl;
    bus.key_in   = k;
    w = 0;
    while (bus.in_ready !== 1'b1 && w < 200) begin
      tick();
      w++;
    end
    if (w >= 200) begin
      n_cmp++;
      n_bad++;
      $display("FAIL in_ready_timeout: got in_ready=%b, expected 1 within 200 cycles", bus.in_ready);
    end
    tick();
    if (kl) model_key = k;
    bus.key_load = 1'b0;
    if (!hold) bus.in_valid = 1'b0;
  endtask

  task automatic send_block(input logic [63:0] pt, input logic [63:0] ct, input int max_gap,
                            input bit hold, input bit key8, input logic [63:0] k8);
    for (int k = 0; k < 8; k++) begin
      send_byte(pt[63-8*k -: 8], (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0, hold, key8 && (k == 7), k8);
      n_cmp++;
      if (bus.busy !== 1'b1) begin
        n_bad++;
        $display("FAIL busy_after_byte%0d: got %b expected 1", k, bus.busy);
      end
    end
    n_cmp++;
    if (bus.plain_text !== pt) begin
      n_bad++;
      $display("FAIL plain_text: got %h expected %h", bus.plain_text, pt);
    end
    for (int k = 0; k < 8; k++) exp_q.push_back(ct[63-8*k -: 8]);
  endtask

  task automatic wait_drain();
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < 300) begin
      tick();
      w++;
    end
    w = 0;
    while (bus.in_ready !== 1'b1 && w < 20) begin
      tick();
      w++;
    end
    n_cmp++;
    if (exp_q.size() != 0 || bus.in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL drain: got %0d pending bytes, in_ready=%b, expected 0 pending, in_ready=1", exp_q.size(), bus.in_ready);
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    n_cmp++;
    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || bus.out_data !== 8'h00 || bus.busy !== 1'b0 ||
        bus.plain_text !== 64'd0 || bus.cipher_key !== 64'd0) begin
      n_bad++;
      $display("FAIL %s: got rdy=%b vld=%b data=%h busy=%b pt=%h key=%h, expected all zero", tag,
               bus.in_ready, bus.out_valid, bus.out_data, bus.busy, bus.plain_text, bus.cipher_key);
    end
  endtask

  task automatic load_key(input logic [63:0] k);
    bus.key_in   = k;
    bus.key_load = 1'b1;
    tick();
    bus.key_load = 1'b0;
    model_key = k;
    n_cmp++;
    if (bus.cipher_key !== model_key) begin
      n_bad++;
      $display("FAIL key_load: got %h expected %h", bus.cipher_key, model_key);
    end
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #1;
    check_zero_outputs("reset_values");
    tick();
    tick();
    check_zero_outputs("reset_held");
    rst = 1'b0;
    n_cmp++;
    if (bus.in_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL in_ready_before_edge: got %b expected 0", bus.in_ready);
    end
    tick();
    n_cmp++;
    if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
      n_bad++;
      $display("FAIL in_ready_after_edge: got rdy=%b busy=%b expected rdy=1 busy=0", bus.in_ready, bus.busy);
    end
  endtask

  task automatic test_known_answer();
    load_key(KAT_KEY);
    send_block(64'h0123456789ABCDEF, 64'h85E813540F0AB405, 0, 1'b0, 1'b0, 64'd0);
    wait_drain();
  endtask

  task automatic test_latency();
    logic [63:0] pt;
    int n;
    pt = {$urandom, $urandom};
    send_block(pt, des_enc(pt, model_key), 0, 1'b0, 1'b0, 64'd0);
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 20) begin
      n_cmp++;
      if (bus.in_ready !== 1'b0) begin
        n_bad++;
        $display("FAIL in_ready_settle: got %b expected 0", bus.in_ready);
      end
      tick();
      n++;
    end
    n_cmp++;
    if (n != SETTLE) begin
      n_bad++;
      $display("FAIL latency: got out_valid at T+%0d expected T+%0d", n + 1, SETTLE + 1);
    end
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      n_cmp++;
      if (bus.in_ready !== 1'b0) begin
        n_bad++;
        $display("FAIL in_ready_drain: got %b expected 0", bus.in_ready);
      end
      tick();
      n++;
    end
    n_cmp++;
    if (bus.in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL in_ready_reopen: got %b expected 1", bus.in_ready);
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] pt;
    logic [7:0]  held;
    int w;
    pt = {$urandom, $urandom};
    send_block(pt, des_enc(pt, model_key), 3, 1'b0, 1'b0, 64'd0);
    w = 0;
    while (exp_q.size() > 6 && w < 100) begin
      tick();
      w++;
    end
    bus.out_ready = 1'b0;
    held = bus.out_data;
    n_cmp++;
    if (bus.out_valid !== 1'b1 || held !== exp_q[0]) begin
      n_bad++;
      $display("FAIL stall_start: got valid=%b data=%h expected valid=1 data=%h", bus.out_valid, held, exp_q[0]);
    end
    repeat (5) tick();
    n_cmp++;
    if (bus.out_data !== held || exp_q.size() != 6) begin
      n_bad++;
      $display("FAIL stall_end: got data=%h pending=%0d expected data=%h pending=6", bus.out_data, exp_q.size(), held);
    end
    bus.out_ready = 1'b1;
    wait_drain();
  endtask

  task automatic test_key_timing();
    logic [63:0] pt;
    pt = {$urandom, $urandom};
    send_block(pt, des_enc(pt, model_key), 0, 1'b0, 1'b0, 64'd0);
    bus.key_in   = 64'hFFFF_FFFF_FFFF_FFFF;
    bus.key_load = 1'b1;
    tick();
    bus.key_load = 1'b0;
    n_cmp++;
    if (bus.cipher_key !== model_key) begin
      n_bad++;
      $display("FAIL key_in_settle: got %h expected %h", bus.cipher_key, model_key);
    end
    wait_drain();
    load_key(64'hFFFF_FFFF_FFFF_FFFF);
    pt = {$urandom, $urandom};
    send_block(pt, des_enc(pt, model_key), 0, 1'b0, 1'b0, 64'd0);
    wait_drain();
  endtask

  task automatic test_reset_mid();
    logic [63:0] pt;
    int w;
    for (int k = 0; k < 3; k++) send_byte(8'(k + 8'h10), 0, 1'b0, 1'b0, 64'd0);
    #2 rst = 1'b1;
    #1;
    check_zero_outputs("reset_mid_fill");
    rst = 1'b0;
    exp_q.delete();
    model_key = 64'd0;
    load_key(KAT_KEY);
    send_block(64'h0123456789ABCDEF, 64'h85E813540F0AB405, 0, 1'b0, 1'b0, 64'd0);
    wait_drain();
    pt = {$urandom, $urandom};
    send_block(pt, des_enc(pt, model_key), 0, 1'b0, 1'b0, 64'd0);
    w = 0;
    while (exp_q.size() > 5 && w < 100) begin
      tick();
      w++;
    end
    #2 rst = 1'b1;
    #1;
    check_zero_outputs("reset_mid_drain");
    rst = 1'b0;
    exp_q.delete();
    model_key = 64'd0;
    tick();
    n_cmp++;
    if (bus.cipher_key !== 64'd0 || bus.out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL after_reset: got key=%h valid=%b expected key=0 valid=0", bus.cipher_key, bus.out_valid);
    end
    load_key({$urandom, $urandom});
    pt = {$urandom, $urandom};
    send_block(pt, des_enc(pt, model_key), 2, 1'b0, 1'b0, 64'd0);
    wait_drain();
  endtask

  task automatic test_back_to_back();
    logic [63:0] pt, knew, kuse;
    int w;
    bus.out_ready = 1'b1;
    knew = {$urandom, $urandom};
    n_cmp++;
    if (bus.busy !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL b2b_idle: got busy=%b rdy=%b expected busy=0 rdy=1", bus.busy, bus.in_ready);
    end
    for (int b = 0; b < 4; b++) begin
      pt = {$urandom, $urandom};
      kuse = (b == 2) ? knew : model_key;
      send_block(pt, des_enc(pt, kuse), 0, 1'b1, b == 2, knew);
      w = 0;
      while (bus.in_ready !== 1'b1 && w < 100) begin
        n_cmp++;
        if (bus.busy !== 1'b1) begin
          n_bad++;
          $display("FAIL b2b_busy_block%0d: got %b expected 1", b, bus.busy);
        end
        tick();
        w++;
      end
      n_cmp++;
      if (bus.busy !== 1'b0 || exp_q.size() != 0) begin
        n_bad++;
        $display("FAIL b2b_gap_block%0d: got busy=%b pending=%0d expected busy=0 pending=0", b, bus.busy, exp_q.size());
      end
    end
    bus.in_valid = 1'b0;
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.key_load  = 1'b0;
    bus.key_in    = 64'd0;
    bus.out_ready = 1'b1;
    test_reset();
    test_known_answer();
    test_latency();
    test_backpressure();
    test_key_timing();
    test_reset_mid();
    test_back_to_back();
    repeat (3) tick();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL final_pending: got %0d bytes expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish by 500000 time units, expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
